// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives a variable-latency req/ack data port from the EX/MEM
// register, stalls upstream while an access is outstanding and builds the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [72:0] ex_mem,
  output logic [70:0] mem_wb,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_regwrite,
  output logic [31:0] ex_mem_data,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_regwrite,
  output logic [31:0] mem_wb_data,
  input  logic        err_clr,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic        memtoreg, regwrite, memwrite, memread;
  logic [31:0] alu, wdata;
  logic [4:0]  dest;
  logic        memop, aligned, misaligned;
  logic        ack_done, timeout;
  logic [31:0] load_data;
  logic [70:0] wb_next;

  assign memtoreg   = ex_mem[72];
  assign regwrite   = ex_mem[71];
  assign memwrite   = ex_mem[70];
  assign memread    = ex_mem[69];
  assign alu        = ex_mem[68:37];
  assign wdata      = ex_mem[36:5];
  assign dest       = ex_mem[4:0];

  assign memop      = memread | memwrite;
  assign aligned    = (ex_mem[38:37] == 2'b00);
  assign misaligned = memop & ~aligned;

  // Read+write together is a store, so dmem_we follows memwrite alone.
  assign dmem_req   = memop & aligned;
  assign dmem_we    = memwrite & dmem_req;
  assign dmem_addr  = alu;
  assign dmem_wdata = wdata;

  assign ack_done   = dmem_req & dmem_ack;
  // An ack in the last allowed cycle wins over the timeout.
  assign timeout    = dmem_req & ~dmem_ack & (state_q == StWait) & (cnt_q == CntLast);
  assign mem_stall  = dmem_req & ~dmem_ack & ~timeout;

  assign load_data  = (ack_done & memread & ~memwrite) ? dmem_rdata : 32'h0;
  assign wb_next    = {memtoreg, regwrite & ~misaligned, load_data, alu, dest};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_wb       <= '0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      mem_wb <= mem_stall ? 71'h0 : wb_next;
      if (mem_stall) begin
        state_q <= StWait;
        cnt_q   <= (state_q == StIdle) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end else begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end
      if (timeout) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
      if (misaligned) begin
        misalign_err <= 1'b1;
      end else if (err_clr) begin
        misalign_err <= 1'b0;
      end
    end
  end

  assign ex_mem_rd       = dest;
  assign ex_mem_regwrite = regwrite;
  assign ex_mem_data     = alu;

  assign mem_wb_rd       = mem_wb[4:0];
  assign mem_wb_regwrite = mem_wb[69];
  assign mem_wb_data     = mem_wb[70] ? mem_wb[68:37] : mem_wb[36:5];

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random ops checked against a
// transaction-level model (completion cycle, load value and sticky flags per op).
module tb_mem_access_stage;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [72:0] ex_mem;
  logic [70:0] mem_wb;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, err_clr, bus_err, misalign_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, ex_mem_data, mem_wb_data;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic        ex_mem_regwrite, mem_wb_regwrite;

  int total = 0;
  int bad   = 0;
  logic exp_bus = 1'b0;
  logic exp_mis = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .ex_mem(ex_mem), .mem_wb(mem_wb),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_data(ex_mem_data),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_data(mem_wb_data),
    .err_clr(err_clr), .bus_err(bus_err), .misalign_err(misalign_err)
  );

  // One pipeline op; delay = index of the cycle in which the memory acks (0 = same cycle).
  task automatic drive_op(input logic m2r, input logic rw, input logic mw, input logic mr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] dest, input int delay, input logic [31:0] rdata,
                          input logic clr, input string name);
    logic memop, mis, access, is_load, tout;
    int k;
    logic [31:0] lv, exp_data;
    logic [70:0] exp_wb;
    memop   = mw | mr;
    mis     = memop && (addr[1:0] != 2'b00);
    access  = memop && !mis;
    is_load = mr && !mw;
    tout    = access && (delay > int'(TIMEOUT) - 1);
    k       = !access ? 0 : (tout ? int'(TIMEOUT) - 1 : delay);
    lv      = (access && is_load && !tout) ? rdata : 32'h0;
    exp_wb  = {m2r, rw && !mis, lv, addr, dest};
    exp_data = m2r ? lv : addr;
    if (tout) exp_bus = 1'b1; else if (clr) exp_bus = 1'b0;
    if (mis)  exp_mis = 1'b1; else if (clr) exp_mis = 1'b0;
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      ex_mem  = {m2r, rw, mw, mr, addr, wdata, dest};
      err_clr = (c == k) ? clr : 1'b0;
      if (access) begin
        dmem_ack   = (c == delay);
        dmem_rdata = (c == delay) ? rdata : $urandom;
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      #1;
      total++;
      if (dmem_req !== access) begin
        bad++; $display("FAIL %s req c=%0d got=%b exp=%b", name, c, dmem_req, access);
      end
      total++;
      if (mem_stall !== (access && c < k)) begin
        bad++; $display("FAIL %s stall c=%0d got=%b exp=%b", name, c, mem_stall, access && c < k);
      end
      if (access) begin
        total++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {mw, addr, wdata}) begin
          bad++; $display("FAIL %s bus c=%0d got=%b/%h/%h exp=%b/%h/%h", name, c,
                          dmem_we, dmem_addr, dmem_wdata, mw, addr, wdata);
        end
      end
      if (c == 0) begin
        total++;
        if ({ex_mem_rd, ex_mem_regwrite, ex_mem_data} !== {dest, rw, addr}) begin
          bad++; $display("FAIL %s exfwd got=%h/%b/%h exp=%h/%b/%h", name,
                          ex_mem_rd, ex_mem_regwrite, ex_mem_data, dest, rw, addr);
        end
      end
      @(posedge clk); #1;
      if (c < k) begin
        total++;
        if (mem_wb !== 71'h0) begin
          bad++; $display("FAIL %s bubble c=%0d got=%h exp=0", name, c, mem_wb);
        end
      end else begin
        total++;
        if (mem_wb !== exp_wb) begin
          bad++; $display("FAIL %s mem_wb got=%h exp=%h", name, mem_wb, exp_wb);
        end
        total++;
        if ({mem_wb_data, mem_wb_rd, mem_wb_regwrite} !== {exp_data, dest, rw && !mis}) begin
          bad++; $display("FAIL %s wbfwd got=%h/%h/%b exp=%h/%h/%b", name, mem_wb_data,
                          mem_wb_rd, mem_wb_regwrite, exp_data, dest, rw && !mis);
        end
        total++;
        if ({bus_err, misalign_err} !== {exp_bus, exp_mis}) begin
          bad++; $display("FAIL %s errs got=%b%b exp=%b%b", name, bus_err, misalign_err,
                          exp_bus, exp_mis);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_mem = '0; dmem_ack = 1'b0; dmem_rdata = '0; err_clr = 1'b0;
    #3;
    total++;
    if ({mem_wb, dmem_req, mem_stall, bus_err, misalign_err} !== 75'h0) begin
      bad++; $display("FAIL reset got wb=%h req=%b stall=%b be=%b me=%b exp=all zero",
                      mem_wb, dmem_req, mem_stall, bus_err, misalign_err);
    end
    @(negedge clk); rst = 1'b0;
    exp_bus = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic test_alu();
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0, 1'b0, "alu");
    drive_op(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_5555, 5'd31, 0, 32'h0, 1'b0,
             "alu_norw");
  endtask

  task automatic test_load_same_cycle();
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 0, 32'hDEAD_BEEF, 1'b0,
             "load_ack0");
  endtask

  task automatic test_store_delay();
    drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h1234_5678, 5'd0, 3, 32'hCAFE_0000,
             1'b0, "store_ack3");
    drive_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0108, 32'h0BAD_F00D, 5'd2, 1, 32'h1111_2222,
             1'b0, "rw_as_store");
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 5'd9, 100, 32'h0, 1'b0, "timeout");
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd3, 0, 32'h0, 1'b1, "clr_bus");
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd4, TIMEOUT - 1, 32'h5A5A_A5A5,
             1'b0, "ack_at_limit");
  endtask

  task automatic test_misaligned();
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd6, 0, 32'h7777_7777, 1'b0,
             "mis_load");
    drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0401, 32'h9999_9999, 5'd1, 0, 32'h0, 1'b1,
             "mis_store_clr");
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 5'd8, 0, 32'h0, 1'b1, "clr_mis");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    ex_mem = {1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 5'd10};
    dmem_ack = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (mem_stall !== 1'b1) begin
      bad++; $display("FAIL rst_wait stall_before got=%b exp=1", mem_stall);
    end
    @(posedge clk); #2;
    rst = 1'b1; ex_mem = '0;
    #1;
    total++;
    if ({mem_wb, dmem_req, mem_stall, bus_err, misalign_err} !== 75'h0) begin
      bad++; $display("FAIL rst_wait in_reset got wb=%h req=%b stall=%b errs=%b%b exp=0",
                      mem_wb, dmem_req, mem_stall, bus_err, misalign_err);
    end
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFEED_FACE;
    exp_bus = 1'b0; exp_mis = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({mem_wb, mem_stall, bus_err, misalign_err} !== 74'h0) begin
      bad++; $display("FAIL rst_wait late_ack got wb=%h stall=%b errs=%b%b exp=0",
                      mem_wb, mem_stall, bus_err, misalign_err);
    end
    // A stale wait counter would time this out before the ack arrives.
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0600, 32'h0, 5'd11, TIMEOUT - 1, 32'h0123_4567,
             1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      int kind, delay;
      kind = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      delay = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT + 2)
                                          : $urandom_range(0, 3);
      drive_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), kind[1], kind[0], addr,
               $urandom, 5'($urandom_range(0, 31)), delay, $urandom,
               ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_same_cycle();
    test_store_delay();
    test_timeout();
    test_misaligned();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
